pc_sequencer: RTL and testbench

//  Parametrised program-counter unit for the pipelined core, replacing the single-cycle PC register.

---
 rtl/pc_sequencer.sv | 151 +++++++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program-counter unit for the pipelined core. Holds the fetch PC and picks
// the next PC from, in priority order: trap vector, resolved redirect target,
// hold (hazard stall), return-address-stack prediction, sequential increment.
// A circular return-address stack (RAS) tracks call/return pairs.
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          asynchronous active-low reset
//   PC_Write       1 = advance PC, 0 = hold (stall)
//   branch_taken   resolved redirect this cycle
//   branch_target  redirect target
//   trap           exception: PC <- trap_vec, RAS emptied
//   trap_vec       trap handler address
//   call           instruction at PC_Out is a call (push PC_Out+INST_BYTES)
//   ret            instruction at PC_Out is a return (pop, predict target)
//   PC_Out         registered fetch PC
//   PC_Next        combinational next-PC
//   ras_count      number of valid RAS entries, 0..RAS_DEPTH
//   ras_empty      ras_count == 0
//   ras_full       ras_count == RAS_DEPTH
//   ras_underflow  one-cycle registered pulse after a ret on an empty RAS
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              INST_BYTES = 4,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PC_Write,
  input  logic                         branch_taken,
  input  logic [XLEN-1:0]              branch_target,
  input  logic                         trap,
  input  logic [XLEN-1:0]              trap_vec,
  input  logic                         call,
  input  logic                         ret,
  output logic [XLEN-1:0]              PC_Out,
  output logic [XLEN-1:0]              PC_Next,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_underflow
);

  localparam int              PW      = $clog2(RAS_DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_top;
  logic [CW-1:0]   r_count;
  logic            r_underflow;

  logic [XLEN-1:0] w_seq;
  logic            w_accept;
  logic            w_empty;
  logic            w_full;
  logic [XLEN-1:0] w_next;
  logic            w_ras_we;
  logic [PW-1:0]   w_ras_waddr;
  logic [PW-1:0]   w_top_next;
  logic [CW-1:0]   w_count_next;
  logic            w_uf_next;

  // Sequential address doubles as the return address pushed on a call;
  // the addition wraps naturally modulo 2^XLEN.
  assign w_seq    = r_pc + XLEN'(INST_BYTES);
  assign w_accept = !trap && (PC_Write || branch_taken);
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == DEPTH_C);

  always_comb begin
    w_next = w_seq;
    if (trap)
      w_next = trap_vec;
    else if (branch_taken)
      w_next = branch_target;
    else if (!PC_Write)
      w_next = r_pc;
    else if (ret && !w_empty)
      w_next = r_ras[r_top];
  end

  // RAS control. r_top always names the most recent entry; a push writes
  // one slot ahead, so on overflow the oldest slot is silently reused.
  // A simultaneous call+ret rewrites the top slot in place.
  always_comb begin
    w_ras_we     = 1'b0;
    w_ras_waddr  = r_top;
    w_top_next   = r_top;
    w_count_next = r_count;
    w_uf_next    = 1'b0;
    if (trap) begin
      w_count_next = '0;
    end else if (w_accept) begin
      if (call && ret) begin
        w_ras_we    = 1'b1;
        w_ras_waddr = r_top;
        if (w_empty) begin
          w_count_next = CW'(1);
          w_uf_next    = 1'b1;
        end
      end else if (call) begin
        w_ras_we    = 1'b1;
        w_ras_waddr = r_top + PW'(1);
        w_top_next  = r_top + PW'(1);
        if (!w_full)
          w_count_next = r_count + CW'(1);
      end else if (ret) begin
        if (!w_empty) begin
          w_top_next   = r_top - PW'(1);
          w_count_next = r_count - CW'(1);
        end else begin
          w_uf_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_VEC;
      r_top       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_next;
      r_top       <= w_top_next;
      r_count     <= w_count_next;
      r_underflow <= w_uf_next;
    end
  end

  // Entry storage is deliberately not reset; only the count marks validity.
  always_ff @(posedge clk) begin
    if (w_ras_we)
      r_ras[w_ras_waddr] <= w_seq;
  end

  assign PC_Out        = r_pc;
  assign PC_Next       = w_next;
  assign ras_count     = r_count;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;
  assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model that keeps the return stack as a bounded queue.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk;
  logic            reset;
  logic            PC_Write;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            trap;
  logic [XLEN-1:0] trap_vec;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] PC_Out;
  logic [XLEN-1:0] PC_Next;
  logic [2:0]      ras_count;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [XLEN-1:0] mPc;
  logic [XLEN-1:0] mRas [$];
  bit              mUf;

  pc_sequencer #(
    .XLEN(XLEN), .RESET_VEC('0), .INST_BYTES(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .PC_Write(PC_Write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap(trap), .trap_vec(trap_vec), .call(call), .ret(ret),
    .PC_Out(PC_Out), .PC_Next(PC_Next), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every registered output against the model
  task automatic checkState(input string tag);
    checkOutput({tag, "/pc"}, PC_Out, mPc);
    checkOutput({tag, "/count"}, 64'(ras_count), 64'(mRas.size()));
    checkOutput({tag, "/empty"}, 64'(ras_empty), 64'(mRas.size() == 0));
    checkOutput({tag, "/full"}, 64'(ras_full), 64'(mRas.size() == DEPTH));
    checkOutput({tag, "/uf"}, 64'(ras_underflow), 64'(mUf));
  endtask

  // Drive one cycle of inputs, check PC_Next, advance the model by the
  // architectural rules, then check the registered outputs after the edge.
  task automatic applyStimulus(input string tag, input bit pw, input bit bt,
                               input logic [XLEN-1:0] tgt, input bit tr,
                               input logic [XLEN-1:0] tv, input bit cl,
                               input bit rt);
    logic [XLEN-1:0] expNext;
    logic [XLEN-1:0] retAddr;
    bit              acc;
    PC_Write = pw; branch_taken = bt; branch_target = tgt;
    trap = tr; trap_vec = tv; call = cl; ret = rt;
    #1;
    retAddr = mPc + 64'd4;
    if (tr)                        expNext = tv;
    else if (bt)                   expNext = tgt;
    else if (!pw)                  expNext = mPc;
    else if (rt && mRas.size() > 0) expNext = mRas[$];
    else                           expNext = retAddr;
    checkOutput({tag, "/next"}, PC_Next, expNext);

    acc = !tr && (pw || bt);
    mUf = 1'b0;
    if (tr) begin
      mRas.delete();
    end else if (acc) begin
      if (cl && rt) begin
        if (mRas.size() > 0) mRas[$] = retAddr;
        else begin mRas.push_back(retAddr); mUf = 1'b1; end
      end else if (cl) begin
        mRas.push_back(retAddr);
        if (mRas.size() > DEPTH) void'(mRas.pop_front());
      end else if (rt) begin
        if (mRas.size() > 0) void'(mRas.pop_back());
        else mUf = 1'b1;
      end
    end
    mPc = expNext;
    @(posedge clk);
    #1;
    checkState(tag);
  endtask

  initial begin
    logic [XLEN-1:0] rTgt;
    logic [XLEN-1:0] rVec;

    reset = 1'b0; PC_Write = 1'b0; branch_taken = 1'b0; branch_target = '0;
    trap = 1'b0; trap_vec = '0; call = 1'b0; ret = 1'b0;
    mPc = '0; mUf = 1'b0; mRas.delete();

    // Reset state and sequential fetch
    #12;
    checkState("reset");
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus("seq", 1, 0, '0, 0, '0, 0, 0);
      checkOutput("seqLit", PC_Out, 64'((i + 1) * 4));
    end

    // Stall holds, then a redirect overrides the stall
    applyStimulus("toX40", 1, 1, 64'h40, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus("stall", 0, 0, '0, 0, '0, 0, 0);
    checkOutput("stallLit", PC_Out, 64'h40);
    applyStimulus("flush", 0, 1, 64'h100, 0, '0, 0, 0);
    checkOutput("flushLit", PC_Out, 64'h100);

    // Call then return
    applyStimulus("toX20", 1, 1, 64'h20, 0, '0, 0, 0);
    applyStimulus("call", 1, 1, 64'h200, 0, '0, 1, 0);
    checkOutput("callCnt", 64'(ras_count), 64'd1);
    applyStimulus("seqA", 1, 0, '0, 0, '0, 0, 0);
    applyStimulus("seqB", 1, 0, '0, 0, '0, 0, 0);
    applyStimulus("ret", 1, 0, '0, 0, '0, 0, 1);
    checkOutput("retLit", PC_Out, 64'h24);

    // Overflow: five calls into a four-deep stack, then drain and underflow
    applyStimulus("toX0", 1, 1, 64'h0, 0, '0, 0, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus("ovCall", 1, 1, 64'((i + 1) * 16), 0, '0, 1, 0);
    checkOutput("ovFull", 64'(ras_count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("ovRet", 1, 0, '0, 0, '0, 0, 1);
      checkOutput("ovRetLit", PC_Out, 64'h44 - 64'(i * 16));
    end
    applyStimulus("underflow", 1, 0, '0, 0, '0, 0, 1);
    checkOutput("ufLit", 64'(ras_underflow), 64'd1);
    applyStimulus("ufClear", 1, 0, '0, 0, '0, 0, 0);
    applyStimulus("callRetEmpty", 1, 0, '0, 0, '0, 1, 1);
    applyStimulus("callRetFull", 1, 0, '0, 0, '0, 1, 1);

    // Trap beats redirect, return and stall, and empties the stack
    applyStimulus("preTrap", 1, 0, '0, 0, '0, 1, 0);
    applyStimulus("trap", 0, 1, 64'h300, 1, 64'h8000, 0, 1);
    checkOutput("trapLit", PC_Out, 64'h8000);
    checkOutput("trapCnt", 64'(ras_count), 64'd0);
    applyStimulus("stallIgnore", 0, 0, '0, 0, '0, 1, 1);

    // Address wrap then asynchronous reset between edges
    applyStimulus("toTop", 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0, 1, 0);
    applyStimulus("wrap", 1, 0, '0, 0, '0, 0, 0);
    checkOutput("wrapLit", PC_Out, 64'h0);
    #3;
    reset = 1'b0;
    #1;
    mPc = '0; mRas.delete(); mUf = 1'b0;
    checkState("asyncReset");
    @(posedge clk);
    #1;
    checkState("resetHeld");
    reset = 1'b1;
    #1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rTgt = {$urandom, $urandom} & ~64'h3;
      rVec = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 15) == 0) rTgt = 64'hFFFF_FFFF_FFFF_FFF8;
      applyStimulus("rand", $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0, rTgt,
                    $urandom_range(0, 31) == 0, rVec,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
